// File: rtl/sha256_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : sha256_pkg
//  Purpose  : Shared types and constants for the SHA-256 compression
//             sequencing logic (round count, message-word count, index
//             width and the controller state encoding).
//  Revision : 1.0 - initial release
// ============================================================================
package sha256_pkg;

   localparam int SHA256_ROUNDS    = 64;
   localparam int SHA256_MSG_WORDS = 16;
   localparam int SHA256_IDX_W     = 7;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_INIT   = 3'd1,
      ST_ROUND  = 3'd2,
      ST_UPDATE = 3'd3,
      ST_OUT    = 3'd4
   } ctrl_state_e;

endpackage : sha256_pkg
`default_nettype wire

// File: rtl/sha256_round_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : sha256_round_ctrl
//  Purpose  : Sequencer for the SHA-256 compression datapath. Accepts one
//             512-bit block per handshake, steps the round index 0..ROUNDS-1
//             and issues the IV/message/state load, round and hash-update
//             strobes, then presents the digest through a valid/ready pair.
//             Holds no data; all block/hash storage lives in the datapath.
//
//  Ports    : clk          - clock, rising-edge
//             rst          - synchronous active-high reset
//             blk_valid    - block presented on the datapath input
//             blk_first    - presented block starts a message
//             blk_last     - presented block ends a message
//             blk_ready    - controller can accept a block (IDLE)
//             abort        - synchronous abandon of the current message
//             k_idx        - round-constant ROM index (0 outside ROUND)
//             iv_load      - load IV into H0..H7
//             msg_load     - latch input block into the W schedule
//             state_load   - copy H0..H7 into a..h
//             round_en     - execute one round this cycle
//             w_sel_msg    - W_t from message (1) or expansion (0)
//             h_update     - H_i <= H_i + working variable
//             digest_valid - H0..H7 hold a final digest
//             digest_ready - consumer accepts the digest
//             busy         - controller not idle
//  Revision : 1.0 - initial release
// ============================================================================
module sha256_round_ctrl
   import sha256_pkg::*;
#(
   parameter int ROUNDS    = SHA256_ROUNDS,
   parameter int MSG_WORDS = SHA256_MSG_WORDS
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    blk_valid,
   input  logic                    blk_first,
   input  logic                    blk_last,
   output logic                    blk_ready,
   input  logic                    abort,
   output logic [SHA256_IDX_W-1:0] k_idx,
   output logic                    iv_load,
   output logic                    msg_load,
   output logic                    state_load,
   output logic                    round_en,
   output logic                    w_sel_msg,
   output logic                    h_update,
   output logic                    digest_valid,
   input  logic                    digest_ready,
   output logic                    busy
);

   localparam logic [SHA256_IDX_W-1:0] LAST_ROUND = SHA256_IDX_W'(ROUNDS - 1);
   localparam logic [SHA256_IDX_W-1:0] MSG_LIMIT  = SHA256_IDX_W'(MSG_WORDS);

   ctrl_state_e             state_q, state_d;
   logic [SHA256_IDX_W-1:0] t_q, t_d;
   logic                    msg_active_q, msg_active_d;
   logic                    last_q, last_d;
   logic                    accept;

   // ------------------------------------------------------------------------
   // State register
   // ------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= ST_IDLE;
         t_q          <= '0;
         msg_active_q <= 1'b0;
         last_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         t_q          <= t_d;
         msg_active_q <= msg_active_d;
         last_q       <= last_d;
      end
   end

   // A block is only taken when nothing overrides it this cycle; abort and
   // reset both suppress the load strobes so the datapath is left untouched.
   assign accept = (state_q == ST_IDLE) && blk_valid && !abort && !rst;

   // ------------------------------------------------------------------------
   // Next-state and output decode
   // ------------------------------------------------------------------------
   always_comb begin
      state_d      = state_q;
      t_d          = t_q;
      msg_active_d = msg_active_q;
      last_d       = last_q;

      blk_ready    = 1'b0;
      k_idx        = '0;
      iv_load      = 1'b0;
      msg_load     = 1'b0;
      state_load   = 1'b0;
      round_en     = 1'b0;
      w_sel_msg    = 1'b0;
      h_update     = 1'b0;
      digest_valid = 1'b0;
      busy         = (state_q != ST_IDLE);

      case (state_q)
         ST_IDLE: begin
            blk_ready = 1'b1;
            if (accept) begin
               msg_load     = 1'b1;
               // A first block restarts the message; a stray non-first block
               // with no message in flight is treated as first.
               iv_load      = blk_first || !msg_active_q;
               last_d       = blk_last;
               msg_active_d = 1'b1;
               t_d          = '0;
               state_d      = ST_INIT;
            end
         end

         ST_INIT: begin
            state_load = 1'b1;
            state_d    = ST_ROUND;
         end

         ST_ROUND: begin
            round_en  = 1'b1;
            k_idx     = t_q;
            w_sel_msg = (t_q < MSG_LIMIT);
            if (t_q == LAST_ROUND) begin
               t_d     = '0;
               state_d = ST_UPDATE;
            end else begin
               t_d = t_q + 1'b1;
            end
         end

         ST_UPDATE: begin
            h_update = 1'b1;
            if (last_q) begin
               msg_active_d = 1'b0;
               state_d      = ST_OUT;
            end else begin
               state_d = ST_IDLE;
            end
         end

         ST_OUT: begin
            digest_valid = 1'b1;
            if (digest_ready) begin
               state_d = ST_IDLE;
            end
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase

      // Abort wins over everything, including a same-cycle accept.
      if (abort) begin
         state_d      = ST_IDLE;
         t_d          = '0;
         msg_active_d = 1'b0;
         last_d       = 1'b0;
      end
   end

endmodule : sha256_round_ctrl
`default_nettype wire

// File: tb/tb_sha256_round_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_sha256_round_ctrl
//  Purpose  : Directed self-checking bench for sha256_round_ctrl. Outputs are
//             packed into one vector and compared against a hand-written
//             cycle schedule of a block (accept at cycle 0).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_sha256_round_ctrl;

   logic       clk;
   logic       rst;
   logic       blk_valid;
   logic       blk_first;
   logic       blk_last;
   logic       blk_ready;
   logic       abort;
   logic [6:0] k_idx;
   logic       iv_load;
   logic       msg_load;
   logic       state_load;
   logic       round_en;
   logic       w_sel_msg;
   logic       h_update;
   logic       digest_valid;
   logic       digest_ready;
   logic       busy;

   int n_checks;
   int n_fail;

   // {blk_ready, k_idx[6:0], iv_load, msg_load, state_load, round_en,
   //  w_sel_msg, h_update, digest_valid, busy}
   logic [15:0] obs;
   assign obs = {blk_ready, k_idx, iv_load, msg_load, state_load, round_en,
                 w_sel_msg, h_update, digest_valid, busy};

   localparam logic [15:0] V_IDLE   = 16'h8000;  // blk_ready only
   localparam logic [15:0] V_ACCEPT = 16'h80C0;  // ready + iv_load + msg_load
   localparam logic [15:0] V_ACC_NOIV = 16'h8040;  // ready + msg_load
   localparam logic [15:0] V_OUT    = 16'h0003;  // digest_valid + busy

   sha256_round_ctrl dut (
      .clk          (clk),
      .rst          (rst),
      .blk_valid    (blk_valid),
      .blk_first    (blk_first),
      .blk_last     (blk_last),
      .blk_ready    (blk_ready),
      .abort        (abort),
      .k_idx        (k_idx),
      .iv_load      (iv_load),
      .msg_load     (msg_load),
      .state_load   (state_load),
      .round_en     (round_en),
      .w_sel_msg    (w_sel_msg),
      .h_update     (h_update),
      .digest_valid (digest_valid),
      .digest_ready (digest_ready),
      .busy         (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Expected outputs c cycles after an accept (c >= 1, blk_valid low).
   function automatic logic [15:0] exp_blk(input int c, input bit last);
      bit         br = 1'b0;
      logic [6:0] k  = 7'd0;
      bit         sl = 1'b0, re = 1'b0, ws = 1'b0, hu = 1'b0, dv = 1'b0;
      bit         bs = 1'b1;
      if (c == 1) begin
         sl = 1'b1;
      end else if (c >= 2 && c <= 65) begin
         re = 1'b1;
         k  = 7'(c - 2);
         ws = (c <= 17);
      end else if (c == 66) begin
         hu = 1'b1;
      end else if (last) begin
         dv = 1'b1;
      end else begin
         bs = 1'b0;
         br = 1'b1;
      end
      return {br, k, 1'b0, 1'b0, sl, re, ws, hu, dv, bs};
   endfunction

   // Advance to just after the next rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         #1;
         n_checks++;
         if (obs !== V_IDLE) begin
            n_fail++;
            $display("FAIL reset_hold cyc=%0d: got %h expected %h", i, obs, V_IDLE);
         end
      end
      rst = 1'b0;
      tick();
      #1;
      n_checks++;
      if (obs !== V_IDLE) begin
         n_fail++;
         $display("FAIL reset_release: got %h expected %h", obs, V_IDLE);
      end
   endtask

   task automatic test_single_block();
      logic [15:0] e;
      tick();
      blk_valid = 1'b1; blk_first = 1'b1; blk_last = 1'b1;
      #1;
      n_checks++;
      if (obs !== V_ACCEPT) begin
         n_fail++;
         $display("FAIL single_accept: got %h expected %h", obs, V_ACCEPT);
      end
      for (int c = 1; c <= 67; c++) begin
         tick();
         if (c == 1) blk_valid = 1'b0;
         #1;
         e = exp_blk(c, 1'b1);
         n_checks++;
         if (obs !== e) begin
            n_fail++;
            $display("FAIL single_sched c=%0d: got %h expected %h", c, obs, e);
         end
      end
      digest_ready = 1'b1;
      tick();
      digest_ready = 1'b0;
      #1;
      n_checks++;
      if (obs !== V_IDLE) begin
         n_fail++;
         $display("FAIL single_release: got %h expected %h", obs, V_IDLE);
      end
   endtask

   // Two-block message with back-to-back accepts; leaves the DUT in OUT.
   task automatic test_back_to_back();
      logic [15:0] e;
      tick();
      blk_valid = 1'b1; blk_first = 1'b1; blk_last = 1'b0;
      #1;
      n_checks++;
      if (obs !== V_ACCEPT) begin
         n_fail++;
         $display("FAIL b2b_accept1: got %h expected %h", obs, V_ACCEPT);
      end
      for (int c = 1; c <= 66; c++) begin
         tick();
         if (c == 1) blk_valid = 1'b0;
         #1;
         e = exp_blk(c, 1'b0);
         n_checks++;
         if (obs !== e) begin
            n_fail++;
            $display("FAIL b2b_blk1 c=%0d: got %h expected %h", c, obs, e);
         end
      end
      // Cycle 67: back in IDLE, continuation block must not reload the IV.
      tick();
      blk_valid = 1'b1; blk_first = 1'b0; blk_last = 1'b1;
      #1;
      n_checks++;
      if (obs !== V_ACC_NOIV) begin
         n_fail++;
         $display("FAIL b2b_accept2: got %h expected %h", obs, V_ACC_NOIV);
      end
      for (int c = 68; c <= 134; c++) begin
         tick();
         if (c == 68) blk_valid = 1'b0;
         #1;
         e = exp_blk(c - 67, 1'b1);
         n_checks++;
         if (obs !== e) begin
            n_fail++;
            $display("FAIL b2b_blk2 c=%0d: got %h expected %h", c, obs, e);
         end
      end
   endtask

   // Starts in OUT. A block waits during OUT and is taken the cycle IDLE
   // is re-entered; that block is left running for the abort test.
   task automatic test_backpressure();
      blk_valid = 1'b1; blk_first = 1'b0; blk_last = 1'b1;
      for (int i = 0; i < 10; i++) begin
         tick();
         #1;
         n_checks++;
         if (obs !== V_OUT) begin
            n_fail++;
            $display("FAIL bp_hold i=%0d: got %h expected %h", i, obs, V_OUT);
         end
      end
      digest_ready = 1'b1;
      tick();
      digest_ready = 1'b0;
      #1;
      // Message ended, so a non-first block still loads the IV.
      n_checks++;
      if (obs !== V_ACCEPT) begin
         n_fail++;
         $display("FAIL bp_release: got %h expected %h", obs, V_ACCEPT);
      end
   endtask

   task automatic test_abort();
      logic [15:0] e;
      for (int c = 1; c <= 32; c++) begin
         tick();
         if (c == 1)  blk_valid = 1'b0;
         if (c == 32) abort = 1'b1;
         #1;
         e = exp_blk(c, 1'b1);
         n_checks++;
         if (obs !== e) begin
            n_fail++;
            $display("FAIL abort_pre c=%0d: got %h expected %h", c, obs, e);
         end
      end
      tick();
      abort = 1'b0;
      #1;
      n_checks++;
      if (obs !== V_IDLE) begin
         n_fail++;
         $display("FAIL abort_idle: got %h expected %h", obs, V_IDLE);
      end
      for (int i = 0; i < 40; i++) begin
         tick();
         #1;
         n_checks++;
         if (obs !== V_IDLE) begin
            n_fail++;
            $display("FAIL abort_quiet i=%0d: got %h expected %h", i, obs, V_IDLE);
         end
      end
      tick();
      blk_valid = 1'b1; blk_first = 1'b0; blk_last = 1'b1;
      #1;
      n_checks++;
      if (obs !== V_ACCEPT) begin
         n_fail++;
         $display("FAIL abort_next_iv: got %h expected %h", obs, V_ACCEPT);
      end
      for (int c = 1; c <= 67; c++) begin
         tick();
         if (c == 1) blk_valid = 1'b0;
         #1;
         e = exp_blk(c, 1'b1);
         n_checks++;
         if (obs !== e) begin
            n_fail++;
            $display("FAIL abort_next c=%0d: got %h expected %h", c, obs, e);
         end
      end
      digest_ready = 1'b1;
      tick();
      digest_ready = 1'b0;
      #1;
      n_checks++;
      if (obs !== V_IDLE) begin
         n_fail++;
         $display("FAIL abort_next_release: got %h expected %h", obs, V_IDLE);
      end
   endtask

   // First block of a new message while one is active reloads the IV.
   task automatic test_restart();
      logic [15:0] e;
      tick();
      blk_valid = 1'b1; blk_first = 1'b1; blk_last = 1'b0;
      #1;
      n_checks++;
      if (obs !== V_ACCEPT) begin
         n_fail++;
         $display("FAIL restart_accept1: got %h expected %h", obs, V_ACCEPT);
      end
      for (int c = 1; c <= 66; c++) begin
         tick();
         if (c == 1) blk_valid = 1'b0;
         #1;
         e = exp_blk(c, 1'b0);
         n_checks++;
         if (obs !== e) begin
            n_fail++;
            $display("FAIL restart_blk1 c=%0d: got %h expected %h", c, obs, e);
         end
      end
      tick();
      blk_valid = 1'b1; blk_first = 1'b1; blk_last = 1'b1;
      #1;
      n_checks++;
      if (obs !== V_ACCEPT) begin
         n_fail++;
         $display("FAIL restart_accept2: got %h expected %h", obs, V_ACCEPT);
      end
      tick();
      blk_valid = 1'b0;
      // Mid-block reset returns to IDLE with no strobes.
      rst = 1'b1;
      #1;
      n_checks++;
      if (obs !== exp_blk(1, 1'b1)) begin
         n_fail++;
         $display("FAIL restart_init: got %h expected %h", obs, exp_blk(1, 1'b1));
      end
      tick();
      rst = 1'b0;
      #1;
      n_checks++;
      if (obs !== V_IDLE) begin
         n_fail++;
         $display("FAIL restart_rst_mid: got %h expected %h", obs, V_IDLE);
      end
   endtask

   task automatic test_simultaneous();
      logic [15:0] e;
      tick();
      abort = 1'b1; blk_valid = 1'b1; blk_first = 1'b1; blk_last = 1'b1;
      #1;
      n_checks++;
      if (obs !== V_IDLE) begin
         n_fail++;
         $display("FAIL sim_abort_accept: got %h expected %h", obs, V_IDLE);
      end
      tick();
      abort = 1'b0; blk_valid = 1'b0;
      #1;
      n_checks++;
      if (obs !== V_IDLE) begin
         n_fail++;
         $display("FAIL sim_abort_stay: got %h expected %h", obs, V_IDLE);
      end
      tick();
      blk_valid = 1'b1;
      #1;
      n_checks++;
      if (obs !== V_ACCEPT) begin
         n_fail++;
         $display("FAIL sim_accept: got %h expected %h", obs, V_ACCEPT);
      end
      for (int c = 1; c <= 67; c++) begin
         tick();
         if (c == 1) blk_valid = 1'b0;
         #1;
         e = exp_blk(c, 1'b1);
         n_checks++;
         if (obs !== e) begin
            n_fail++;
            $display("FAIL sim_sched c=%0d: got %h expected %h", c, obs, e);
         end
      end
      rst = 1'b1;
      tick();
      rst = 1'b0;
      #1;
      n_checks++;
      if (obs !== V_IDLE) begin
         n_fail++;
         $display("FAIL sim_rst_out: got %h expected %h", obs, V_IDLE);
      end
   endtask

   initial begin
      n_checks     = 0;
      n_fail       = 0;
      rst          = 1'b1;
      blk_valid    = 1'b0;
      blk_first    = 1'b0;
      blk_last     = 1'b0;
      abort        = 1'b0;
      digest_ready = 1'b0;

      test_reset();
      test_single_block();
      test_back_to_back();
      test_backpressure();
      test_abort();
      test_restart();
      test_simultaneous();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule : tb_sha256_round_ctrl
`default_nettype wire

// File: doc/sha256_round_ctrl.md
# sha256_round_ctrl

Sequencing controller for the SHA-256 compression datapath. It accepts 512-bit message blocks through a valid/ready handshake and steps the round index 0..63 that drives the round-constant ROM (`K_t`) and the message-schedule datapath. It issues the load, round and update strobes for the working-variable and hash registers, and presents the final digest through a valid/ready handshake. It holds no data: all 256/512-bit storage lives in the datapath.

## Interface
Parameters:
- `ROUNDS`, 64: compression rounds per block. Fixed by SHA-256; exposed only for bench shortening.
- `MSG_WORDS`, 16: rounds that take `W_t` directly from the message block.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `blk_valid`  in  1  a message block is presented on the datapath input.
- `blk_first`  in  1  presented block is the first of a message; qualified by `blk_valid`.
- `blk_last`  in  1  presented block is the last of a message; qualified by `blk_valid`.
- `blk_ready`  out  1  controller can accept a block.
- `abort`  in  1  synchronous abandon of the current message.
- `k_idx`  out  7  round index to the round-constant ROM `idx`; range 0..63.
- `iv_load`  out  1  one-cycle strobe: load the IV into H0..H7.
- `msg_load`  out  1  one-cycle strobe: latch the input block into the W schedule.
- `state_load`  out  1  one-cycle strobe: copy H0..H7 into a..h.
- `round_en`  out  1  execute one round this cycle.
- `w_sel_msg`  out  1  `W_t` comes from the message (1) or from expansion (0).
- `h_update`  out  1  one-cycle strobe: H_i <= H_i + working variable.
- `digest_valid`  out  1  H0..H7 hold a final digest.
- `digest_ready`  in  1  consumer accepts the digest.
- `busy`  out  1  not in IDLE.

## Operation
- States are IDLE, INIT, ROUND, UPDATE and OUT. A 7-bit round counter `t` and a `msg_active` flag are held alongside.
- **IDLE:**
  - `blk_ready` = 1.
  - On `blk_valid && blk_ready`: `msg_load` = 1 that cycle. `iv_load` = 1 that cycle if `blk_first || !msg_active`.
  - At the same edge: latch `blk_last`, set `msg_active`, clear `t`, go to INIT.
  - `blk_first` while `msg_active` restarts the message (IV reloaded).
  - A non-first block with no active message is treated as first.
- **INIT:** `state_load` = 1 for one cycle, then go to ROUND. H already holds the IV or the previous block's result.
- **ROUND:**
  - `round_en` = 1 and `k_idx` = `t`.
  - `w_sel_msg` = (`t` < `MSG_WORDS`).
  - `t` increments each cycle. At `t` == `ROUNDS`-1, go to UPDATE with `t` cleared.
- **UPDATE:** `h_update` = 1 for one cycle.
  - If the latched `blk_last` is set: go to OUT and clear `msg_active`.
  - Otherwise go to IDLE with `msg_active` kept.
- **OUT:** `digest_valid` = 1, held stable until `digest_ready`. On `digest_valid && digest_ready`, go to IDLE.
- **abort:**
  - In any state, `abort` forces IDLE and clears `msg_active`, `t` and the latched `blk_last`.
  - No `h_update` is issued for a partially processed block.
  - `abort` takes priority over a same-cycle block accept: no strobes are issued and no state changes.
- **Decode:** all strobes and `k_idx` are Moore-decoded from registered state and `t`; no combinational path from inputs to outputs. The exceptions are `msg_load` and `iv_load`, which are qualified by `blk_valid` in IDLE.
- **Out-of-range index:** `k_idx` = 0 outside ROUND; the ROM is never addressed beyond 63.

## Timing
- **Reset values (during and after `rst`):**
  - state = IDLE, `t` = 0, `msg_active` = 0.
  - `k_idx` = 0.
  - `iv_load`, `msg_load`, `state_load`, `round_en`, `w_sel_msg`, `h_update`, `digest_valid`, `busy` = 0.
  - `blk_ready` = 1.
- **Reset mid-operation:** `rst` in any state returns to IDLE the next cycle, with identical effect to `abort`.
- **Per-block schedule (accept at cycle 0):**
  - INIT at cycle 1.
  - ROUND at cycles 2..65, with `k_idx` = 0..63.
  - UPDATE at cycle 66.
  - Cycle 67: IDLE (non-last block) or OUT (last block).
- **Throughput:** 67 cycles per block, accept to accept. With `digest_ready` held high, a last block is accepted to the next first block in 68 cycles.
- **OUT backpressure:** `blk_ready` = 0 throughout OUT. Blocks presented during OUT wait.

## Structure
- Shared package `sha256_pkg`:
  - state enum (IDLE, INIT, ROUND, UPDATE, OUT).
  - `SHA256_ROUNDS` = 64, `SHA256_MSG_WORDS` = 16, `SHA256_IDX_W` = 7.
- The round-constant ROM stays a separate instance. `k_idx` connects directly to its `idx`.
- No sub-module; the counter and FSM are a single block.

## Test plan
- **Reset:** assert `rst` 3 cycles -> all outputs at reset values, `blk_ready` = 1, `k_idx` = 0.
- **Single-block message:** `blk_valid` = `blk_first` = `blk_last` = 1 at cycle 0 -> the following, in order:
  - `iv_load` and `msg_load` at cycle 0, `state_load` at 1.
  - `k_idx` 0..63 at cycles 2..65; `w_sel_msg` high only for cycles 2..17.
  - `h_update` at 66, `digest_valid` from 67.
  - Integrated with the datapath, "abc" yields ba7816bf…f20015ad.
- **Two-block message:** second block has `blk_first` = 0 -> no `iv_load` on the second accept; second accept possible at cycle 67; `digest_valid` only after the second UPDATE (cycle 134 for back-to-back accepts).
- **Digest backpressure:** `digest_ready` held low 10 cycles in OUT -> `digest_valid` stays 1 and `blk_ready` stays 0; IDLE one cycle after `digest_ready` rises.
- **Abort:** `abort` at `k_idx` = 30 -> IDLE next cycle, no `h_update`. The next block with `blk_first` = 0 still asserts `iv_load`.
- **Simultaneous events:** `abort` and `blk_valid` both high in IDLE -> no strobes, state stays IDLE. `rst` during OUT -> `digest_valid` = 0 next cycle.
